// File: rtl/traffic_light_if.sv
// Purpose : signal bundle between the traffic light controller and the board
//           side (debounced buttons/sensor in, LED drivers out).
// Modports: master - board/environment side: drives Sensor, walkButton
//                    (and night_mode when TRAFFIC_NIGHT_MODE_EN is defined),
//                    observes the lights, state_o and tick_o.
//           slave  - controller side: the mirror image of master.
// Macro   : TRAFFIC_NIGHT_MODE_EN adds the night_mode request line.
// Handshake: there is no valid/ready pair here. Inputs are plain levels
//           sampled on every posedge clk; outputs are Moore outputs that
//           change only on posedge clk.
interface traffic_light_if;
  logic       Sensor;
  logic       walkButton;
`ifdef TRAFFIC_NIGHT_MODE_EN
  logic       night_mode;
`endif
  logic       walkLight;
  logic [1:0] mainLight;
  logic [1:0] sideLight;
  logic [3:0] state_o;
  logic       tick_o;

`ifdef TRAFFIC_NIGHT_MODE_EN
  modport master (output Sensor, walkButton, night_mode,
                  input  walkLight, mainLight, sideLight, state_o, tick_o);
  modport slave  (input  Sensor, walkButton, night_mode,
                  output walkLight, mainLight, sideLight, state_o, tick_o);
`else
  modport master (output Sensor, walkButton,
                  input  walkLight, mainLight, sideLight, state_o, tick_o);
  modport slave  (input  Sensor, walkButton,
                  output walkLight, mainLight, sideLight, state_o, tick_o);
`endif
endinterface

// File: rtl/traffic_light_ctrl.sv
// Purpose : main/side intersection controller with pedestrian walk phase and
//           sensor-driven green extension. An internal prescaler makes a 1 s
//           tick; every phase lasts a parameterised number of ticks.
// Ports   : clk  - system clock
//           rst  - synchronous, active-high reset
//           bus  - traffic_light_if.slave: Sensor, walkButton, [night_mode]
//                  in; walkLight, mainLight, sideLight, state_o, tick_o out.
//           Light encoding: 11=G 01=Y 00=R 10=OFF.
// Macro   : TRAFFIC_NIGHT_MODE_EN enables the flashing NIGHT state (code 8)
//           entered from SY while night_mode is high.
module traffic_light_ctrl #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int CNT_W         = 4,
  parameter int T_MAIN_G      = 6,
  parameter int T_SIDE_G      = 6,
  parameter int T_EXT         = 3,
  parameter int T_YEL         = 2,
  parameter int T_WALK        = 3
) (
  input  logic            clk,
  input  logic            rst,
  traffic_light_if.slave  bus
);

  localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_SEC - 1);

  typedef enum logic [3:0] {
    S_MG1    = 4'd0,
    S_MG2    = 4'd1,
    S_MG_EXT = 4'd2,
    S_MY     = 4'd3,
    S_WALK   = 4'd4,
    S_SG1    = 4'd5,
    S_SG_EXT = 4'd6,
`ifdef TRAFFIC_NIGHT_MODE_EN
    S_SY     = 4'd7,
    S_NIGHT  = 4'd8
`else
    S_SY     = 4'd7
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   sec_q, sec_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic               walk_req_q, walk_req_d;
  logic [1:0]         main_q, main_d;
  logic [1:0]         side_q, side_d;
  logic               walk_light_q, walk_light_d;
`ifdef TRAFFIC_NIGHT_MODE_EN
  logic               phase_q, phase_d;
`endif
  logic               tick;
  logic               sec_end;

  // Last seconds-count value of each timed state; the phase ends on the tick
  // that sees this value, so a state lasts exactly T ticks.
  function automatic logic [CNT_W-1:0] last_sec(input state_t s);
    case (s)
      S_MG1, S_MG2:      last_sec = CNT_W'(T_MAIN_G - 1);
      S_MG_EXT, S_SG_EXT: last_sec = CNT_W'(T_EXT - 1);
      S_MY, S_SY:        last_sec = CNT_W'(T_YEL - 1);
      S_WALK:            last_sec = CNT_W'(T_WALK - 1);
      S_SG1:             last_sec = CNT_W'(T_SIDE_G - 1);
      default:           last_sec = '0;
    endcase
  endfunction

  assign tick    = (pre_q == PRE_MAX);
  assign sec_end = tick && (sec_q == last_sec(state_q));

  always_comb begin
    pre_d      = tick ? '0 : pre_q + 1'b1;
    state_d    = state_q;
    sec_d      = tick ? sec_q + 1'b1 : sec_q;
    // A press anywhere but WALK is remembered until the next MY exit.
    walk_req_d = walk_req_q | (bus.walkButton && (state_q != S_WALK));
`ifdef TRAFFIC_NIGHT_MODE_EN
    phase_d    = phase_q;
`endif

    case (state_q)
      S_MG1:    if (sec_end) state_d = bus.Sensor ? S_MG_EXT : S_MG2;
      S_MG2:    if (sec_end) state_d = S_MY;
      S_MG_EXT: if (sec_end) state_d = S_MY;
      S_MY:     if (sec_end) state_d = (walk_req_q || bus.walkButton) ? S_WALK : S_SG1;
      S_WALK:   if (sec_end) state_d = S_SG1;
      S_SG1:    if (sec_end) state_d = bus.Sensor ? S_SG_EXT : S_SY;
      S_SG_EXT: if (sec_end) state_d = S_SY;
`ifdef TRAFFIC_NIGHT_MODE_EN
      S_SY:     if (sec_end) state_d = bus.night_mode ? S_NIGHT : S_MG1;
      S_NIGHT: begin
        // Untimed: the seconds counter is parked and each tick flips the
        // flash phase until night_mode drops.
        sec_d = '0;
        if (tick) begin
          phase_d = ~phase_q;
          if (!bus.night_mode) state_d = S_MG1;
        end
      end
`else
      S_SY:     if (sec_end) state_d = S_MG1;
`endif
      default: begin
        state_d = S_MG1;
        sec_d   = '0;
      end
    endcase

    if (sec_end) sec_d = '0;

    // Entering WALK serves the request; clearing beats a same-cycle press.
    if ((state_d == S_WALK) && (state_q != S_WALK)) walk_req_d = 1'b0;

`ifdef TRAFFIC_NIGHT_MODE_EN
    if ((state_d == S_NIGHT) && (state_q != S_NIGHT)) phase_d = 1'b0;
`endif

    // Lights are decoded from the next state so the registered outputs
    // always match the state register.
    main_d       = 2'b00;
    side_d       = 2'b00;
    walk_light_d = 1'b0;
    case (state_d)
      S_MG1, S_MG2, S_MG_EXT: main_d = 2'b11;
      S_MY:                   main_d = 2'b01;
      S_WALK:                 walk_light_d = 1'b1;
      S_SG1, S_SG_EXT:        side_d = 2'b11;
      S_SY:                   side_d = 2'b01;
`ifdef TRAFFIC_NIGHT_MODE_EN
      S_NIGHT: begin
        main_d = phase_d ? 2'b10 : 2'b01;
        side_d = phase_d ? 2'b10 : 2'b00;
      end
`endif
      default: main_d = 2'b11;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_MG1;
      sec_q        <= '0;
      pre_q        <= '0;
      walk_req_q   <= 1'b0;
      main_q       <= 2'b11;
      side_q       <= 2'b00;
      walk_light_q <= 1'b0;
`ifdef TRAFFIC_NIGHT_MODE_EN
      phase_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sec_q        <= sec_d;
      pre_q        <= pre_d;
      walk_req_q   <= walk_req_d;
      main_q       <= main_d;
      side_q       <= side_d;
      walk_light_q <= walk_light_d;
`ifdef TRAFFIC_NIGHT_MODE_EN
      phase_q      <= phase_d;
`endif
    end
  end

  assign bus.mainLight = main_q;
  assign bus.sideLight = side_q;
  assign bus.walkLight = walk_light_q;
  assign bus.state_o   = state_q;
  assign bus.tick_o    = tick;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl with TICKS_PER_SEC=4 and default
// phase lengths: one second = 4 cycles, so MG/SG = 24, EXT = 12, Y = 8,
// WALK = 12 cycles. Outputs are sampled and inputs driven on negedge clk.
module tb_traffic_light_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  traffic_light_if tl_if ();

  traffic_light_ctrl #(
    .TICKS_PER_SEC (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (tl_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] st, input logic [1:0] m,
                            input logic [1:0] s, input logic w);
    check({tag, ".state"}, 32'(tl_if.state_o), 32'(st));
    check({tag, ".main"},  32'(tl_if.mainLight), 32'(m));
    check({tag, ".side"},  32'(tl_if.sideLight), 32'(s));
    check({tag, ".walk"},  32'(tl_if.walkLight), 32'(w));
  endtask

  // Called at the negedge of the first cycle of a state: checks the lights,
  // then counts cycles until the state changes. pulse_at>0 raises walkButton
  // for exactly that cycle of the state.
  task automatic measure(input string tag, input logic [3:0] st, input logic [1:0] m,
                         input logic [1:0] s, input logic w, input int exp_len,
                         input int pulse_at);
    int n;
    check_outs(tag, st, m, s, w);
    n = 1;
    tl_if.walkButton = (pulse_at == 1);
    while (n < 300) begin
      @(negedge clk);
      if (tl_if.state_o != st) break;
      n++;
      tl_if.walkButton = (n == pulse_at);
    end
    tl_if.walkButton = 1'b0;
    check({tag, ".len"}, 32'(n), 32'(exp_len));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    tl_if.Sensor     = 1'b0;
    tl_if.walkButton = 1'b0;
`ifdef TRAFFIC_NIGHT_MODE_EN
    tl_if.night_mode = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset values and prescaler phase: tick only in the 4th cycle.
    check_outs("rst", 4'd0, 2'b11, 2'b00, 1'b0);
    check("tick_c1", 32'(tl_if.tick_o), 32'd0);
    @(negedge clk); check("tick_c2", 32'(tl_if.tick_o), 32'd0);
    @(negedge clk); check("tick_c3", 32'(tl_if.tick_o), 32'd0);
    @(negedge clk); check("tick_c4", 32'(tl_if.tick_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // No sensor, no walk.
    measure("n_mg1", 4'd0, 2'b11, 2'b00, 1'b0, 24, 0);
    measure("n_mg2", 4'd1, 2'b11, 2'b00, 1'b0, 24, 0);
    measure("n_my",  4'd3, 2'b01, 2'b00, 1'b0, 8, 0);
    measure("n_sg1", 4'd5, 2'b00, 2'b11, 1'b0, 24, 0);
    measure("n_sy",  4'd7, 2'b00, 2'b01, 1'b0, 8, 0);

    // Sensor held high: both greens extended.
    tl_if.Sensor = 1'b1;
    measure("s_mg1",  4'd0, 2'b11, 2'b00, 1'b0, 24, 0);
    measure("s_mgx",  4'd2, 2'b11, 2'b00, 1'b0, 12, 0);
    measure("s_my",   4'd3, 2'b01, 2'b00, 1'b0, 8, 0);
    measure("s_sg1",  4'd5, 2'b00, 2'b11, 1'b0, 24, 0);
    tl_if.Sensor = 1'b0;
    measure("s_sgx",  4'd6, 2'b00, 2'b11, 1'b0, 12, 0);
    measure("s_sy",   4'd7, 2'b00, 2'b01, 1'b0, 8, 0);

    // Walk pulse in MG1; another press during WALK must be ignored.
    measure("w_mg1",  4'd0, 2'b11, 2'b00, 1'b0, 24, 3);
    measure("w_mg2",  4'd1, 2'b11, 2'b00, 1'b0, 24, 0);
    measure("w_my",   4'd3, 2'b01, 2'b00, 1'b0, 8, 0);
    measure("w_walk", 4'd4, 2'b00, 2'b00, 1'b1, 12, 5);
    measure("w_sg1",  4'd5, 2'b00, 2'b11, 1'b0, 24, 0);
    measure("w_sy",   4'd7, 2'b00, 2'b01, 1'b0, 8, 0);
    measure("w2_mg1", 4'd0, 2'b11, 2'b00, 1'b0, 24, 0);
    measure("w2_mg2", 4'd1, 2'b11, 2'b00, 1'b0, 24, 0);
    measure("w2_my",  4'd3, 2'b01, 2'b00, 1'b0, 8, 0);
    measure("w2_sg1", 4'd5, 2'b00, 2'b11, 1'b0, 24, 0);
    measure("w2_sy",  4'd7, 2'b00, 2'b01, 1'b0, 8, 0);

    // Walk request pending, then reset in the middle of MG2 drops it.
    measure("r_mg1", 4'd0, 2'b11, 2'b00, 1'b0, 24, 2);
    repeat (10) @(negedge clk);
    check("r_mid_state", 32'(tl_if.state_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_outs("r_rst", 4'd0, 2'b11, 2'b00, 1'b0);
    rst = 1'b0;
    measure("r2_mg1", 4'd0, 2'b11, 2'b00, 1'b0, 24, 0);
    measure("r2_mg2", 4'd1, 2'b11, 2'b00, 1'b0, 24, 0);
    measure("r2_my",  4'd3, 2'b01, 2'b00, 1'b0, 8, 0);
    measure("r2_sg1", 4'd5, 2'b00, 2'b11, 1'b0, 24, 0);

`ifdef TRAFFIC_NIGHT_MODE_EN
    // Night flashing: 01/00 then 10/10 every tick, back to MG1 on a tick
    // seen with night_mode low.
    tl_if.night_mode = 1'b1;
    measure("nt_sy", 4'd7, 2'b00, 2'b01, 1'b0, 8, 0);
    check_outs("nt_c1", 4'd8, 2'b01, 2'b00, 1'b0);
    repeat (4) @(negedge clk);
    check_outs("nt_c5", 4'd8, 2'b10, 2'b10, 1'b0);
    repeat (4) @(negedge clk);
    check_outs("nt_c9", 4'd8, 2'b01, 2'b00, 1'b0);
    tl_if.night_mode = 1'b0;
    repeat (3) @(negedge clk);
    check("nt_c12", 32'(tl_if.state_o), 32'd8);
    @(negedge clk);
    check_outs("nt_exit", 4'd0, 2'b11, 2'b00, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
